// File: rtl/regfile_pkg.sv
// Shared constants and types for the register file.
// Configuration macro used elsewhere: REGFILE_WRITE_BYPASS_EN (same-cycle write forwarding).
package regfile_pkg;

   localparam int unsigned DATA_W   = 32;
   localparam int unsigned NUM_REGS = 32;
   localparam int unsigned ADDR_W   = $clog2(NUM_REGS);
   localparam int unsigned ZERO_REG = 0;

   typedef logic [ADDR_W-1:0] reg_idx_t;
   typedef logic [DATA_W-1:0] reg_data_t;

endpackage

// File: rtl/regfile_if.sv
// Write/read bus between the pipeline stages and the register file.
// Master is the pipeline side; slave is the register file.
interface regfile_if;
   import regfile_pkg::*;

   logic        ctrl_writeEnable;
   reg_idx_t    ctrl_writeReg;
   reg_data_t   data_writeReg;
   reg_idx_t    ctrl_readRegA;
   reg_idx_t    ctrl_readRegB;
   reg_data_t   data_readRegA;
   reg_data_t   data_readRegB;
   logic [15:0] write_count;

   modport master (
      output ctrl_writeEnable, ctrl_writeReg, data_writeReg, ctrl_readRegA, ctrl_readRegB,
      input  data_readRegA, data_readRegB, write_count
   );

   modport slave (
      input  ctrl_writeEnable, ctrl_writeReg, data_writeReg, ctrl_readRegA, ctrl_readRegB,
      output data_readRegA, data_readRegB, write_count
   );

endinterface

// File: rtl/regfile_core_reg_32.sv
// Single architectural register with asynchronous active-high clear and load enable.
module reg_32
   import regfile_pkg::*;
(
   input  logic      clock,
   input  logic      ctrl_reset,
   input  logic      en,
   input  reg_data_t d,
   output reg_data_t q
);

   always_ff @(posedge clock or posedge ctrl_reset) begin
      if (ctrl_reset) begin
         q <= '0;
      end else if (en) begin
         q <= d;
      end
   end

endmodule

// File: rtl/regfile_core.sv
// 32x32 register file: one write port, two combinational read ports, r0 hardwired to 0.
// Define REGFILE_WRITE_BYPASS_EN to forward same-cycle write data onto the read ports.
module regfile_core
   import regfile_pkg::*;
(
   input logic      clock,
   input logic      ctrl_reset,
   regfile_if.slave bus
);

   reg_data_t          regs [NUM_REGS];
   logic [NUM_REGS-1:1] reg_en;
   logic               write_commit;
   reg_data_t          read_a;
   reg_data_t          read_b;
   logic [15:0]        count;

   assign write_commit = bus.ctrl_writeEnable && (bus.ctrl_writeReg != reg_idx_t'(ZERO_REG));

   assign regs[0] = '0;

   // One-hot write decode; index 0 has no storage so it can never be enabled.
   for (genvar i = 1; i < NUM_REGS; i++) begin : g_regs
      assign reg_en[i] = write_commit && (bus.ctrl_writeReg == reg_idx_t'(i));

      reg_32 u_reg (
         .clock      (clock),
         .ctrl_reset (ctrl_reset),
         .en         (reg_en[i]),
         .d          (bus.data_writeReg),
         .q          (regs[i])
      );
   end

   always_ff @(posedge clock or posedge ctrl_reset) begin
      if (ctrl_reset) begin
         count <= '0;
      end else if (write_commit) begin
         count <= count + 16'd1;
      end
   end

   // write_commit already excludes index 0, so the bypass can never expose data on r0.
   always_comb begin
      read_a = regs[bus.ctrl_readRegA];
      read_b = regs[bus.ctrl_readRegB];
`ifdef REGFILE_WRITE_BYPASS_EN
      if (write_commit && (bus.ctrl_readRegA == bus.ctrl_writeReg)) begin
         read_a = bus.data_writeReg;
      end
      if (write_commit && (bus.ctrl_readRegB == bus.ctrl_writeReg)) begin
         read_b = bus.data_writeReg;
      end
`else
`endif
   end

   assign bus.data_readRegA = read_a;
   assign bus.data_readRegB = read_b;
   assign bus.write_count   = count;

endmodule

// File: tb/tb_regfile_core.sv
// Directed self-checking bench for regfile_core; expected values are hand-computed constants.
module tb_regfile_core;
   import regfile_pkg::*;

   logic clock;
   logic ctrl_reset;
   int   n_pass;
   int   n_checks;

   regfile_if bus ();

   regfile_core dut (
      .clock      (clock),
      .ctrl_reset (ctrl_reset),
      .bus        (bus.slave)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic write_reg(input reg_idx_t idx, input reg_data_t val);
      @(negedge clock);
      bus.ctrl_writeEnable = 1'b1;
      bus.ctrl_writeReg    = idx;
      bus.data_writeReg    = val;
      @(negedge clock);
      bus.ctrl_writeEnable = 1'b0;
   endtask

   task automatic apply_reset();
      @(negedge clock);
      ctrl_reset = 1'b1;
      repeat (2) @(negedge clock);
      ctrl_reset = 1'b0;
   endtask

   task automatic test_reset();
      ctrl_reset = 1'b1;
      repeat (2) @(negedge clock);
      for (int i = 0; i < 32; i++) begin
         bus.ctrl_readRegA = reg_idx_t'(i);
         bus.ctrl_readRegB = reg_idx_t'(31 - i);
         #1;
         n_checks++;
         if (bus.data_readRegA !== 32'h0) $display("[TB] FAIL reset_readA[%0d] got=%h exp=00000000", i, bus.data_readRegA);
         else n_pass++;
         n_checks++;
         if (bus.data_readRegB !== 32'h0) $display("[TB] FAIL reset_readB[%0d] got=%h exp=00000000", 31 - i, bus.data_readRegB);
         else n_pass++;
      end
      n_checks++;
      if (bus.write_count !== 16'h0) $display("[TB] FAIL reset_count got=%h exp=0000", bus.write_count);
      else n_pass++;
      @(negedge clock);
      ctrl_reset = 1'b0;
   endtask

   task automatic test_basic_write();
      write_reg(5'd5, 32'hDEADBEEF);
      bus.ctrl_readRegA = 5'd5;
      #1;
      n_checks++;
      if (bus.data_readRegA !== 32'hDEADBEEF) $display("[TB] FAIL basic_read got=%h exp=deadbeef", bus.data_readRegA);
      else n_pass++;
      n_checks++;
      if (bus.write_count !== 16'd1) $display("[TB] FAIL basic_count got=%0d exp=1", bus.write_count);
      else n_pass++;
   endtask

   task automatic test_reg0_write();
      write_reg(5'd0, 32'h12345678);
      bus.ctrl_readRegA = 5'd0;
      bus.ctrl_readRegB = 5'd0;
      #1;
      n_checks++;
      if (bus.data_readRegA !== 32'h0) $display("[TB] FAIL r0_readA got=%h exp=00000000", bus.data_readRegA);
      else n_pass++;
      n_checks++;
      if (bus.data_readRegB !== 32'h0) $display("[TB] FAIL r0_readB got=%h exp=00000000", bus.data_readRegB);
      else n_pass++;
      n_checks++;
      if (bus.write_count !== 16'd1) $display("[TB] FAIL r0_count got=%0d exp=1", bus.write_count);
      else n_pass++;
   endtask

   task automatic test_fill_dual_read();
      reg_data_t exp_a;
      reg_data_t exp_b;
      apply_reset();
      for (int i = 1; i < 32; i++) begin
         write_reg(reg_idx_t'(i), 32'h01010101 * i);
      end
      for (int i = 0; i < 32; i++) begin
         bus.ctrl_readRegA = reg_idx_t'(i);
         bus.ctrl_readRegB = reg_idx_t'(31 - i);
         exp_a = 32'h01010101 * i;
         exp_b = 32'h01010101 * (31 - i);
         #1;
         n_checks++;
         if (bus.data_readRegA !== exp_a) $display("[TB] FAIL fill_readA[%0d] got=%h exp=%h", i, bus.data_readRegA, exp_a);
         else n_pass++;
         n_checks++;
         if (bus.data_readRegB !== exp_b) $display("[TB] FAIL fill_readB[%0d] got=%h exp=%h", 31 - i, bus.data_readRegB, exp_b);
         else n_pass++;
      end
      bus.ctrl_readRegA = 5'd12;
      bus.ctrl_readRegB = 5'd12;
      #1;
      n_checks++;
      if (bus.data_readRegA !== 32'h0C0C0C0C || bus.data_readRegB !== 32'h0C0C0C0C)
         $display("[TB] FAIL same_index got A=%h B=%h exp=0c0c0c0c", bus.data_readRegA, bus.data_readRegB);
      else n_pass++;
      n_checks++;
      if (bus.write_count !== 16'd31) $display("[TB] FAIL fill_count got=%0d exp=31", bus.write_count);
      else n_pass++;
   endtask

   task automatic test_same_cycle();
      reg_data_t exp_now;
`ifdef REGFILE_WRITE_BYPASS_EN
      exp_now = 32'h22222222;
`else
      exp_now = 32'h11111111;
`endif
      write_reg(5'd7, 32'h11111111);
      @(negedge clock);
      bus.ctrl_writeEnable = 1'b1;
      bus.ctrl_writeReg    = 5'd7;
      bus.data_writeReg    = 32'h22222222;
      bus.ctrl_readRegA    = 5'd7;
      bus.ctrl_readRegB    = 5'd6;
      #1;
      n_checks++;
      if (bus.data_readRegA !== exp_now) $display("[TB] FAIL same_cycle_now got=%h exp=%h", bus.data_readRegA, exp_now);
      else n_pass++;
      n_checks++;
      if (bus.data_readRegB !== 32'h06060606) $display("[TB] FAIL same_cycle_other got=%h exp=06060606", bus.data_readRegB);
      else n_pass++;
      @(negedge clock);
      bus.ctrl_writeEnable = 1'b0;
      #1;
      n_checks++;
      if (bus.data_readRegA !== 32'h22222222) $display("[TB] FAIL same_cycle_next got=%h exp=22222222", bus.data_readRegA);
      else n_pass++;
      n_checks++;
      if (bus.write_count !== 16'd33) $display("[TB] FAIL same_cycle_count got=%0d exp=33", bus.write_count);
      else n_pass++;
   endtask

   task automatic test_async_reset();
      @(negedge clock);
      bus.ctrl_readRegA    = 5'd3;
      bus.ctrl_readRegB    = 5'd9;
      bus.ctrl_writeEnable = 1'b1;
      bus.ctrl_writeReg    = 5'd9;
      bus.data_writeReg    = 32'hAAAA5555;
      #2;
      ctrl_reset = 1'b1;
      #1;
      n_checks++;
      if (bus.data_readRegA !== 32'h0) $display("[TB] FAIL async_readA got=%h exp=00000000", bus.data_readRegA);
      else n_pass++;
      n_checks++;
      if (bus.data_readRegB !== 32'h0) $display("[TB] FAIL async_readB got=%h exp=00000000", bus.data_readRegB);
      else n_pass++;
      n_checks++;
      if (bus.write_count !== 16'd0) $display("[TB] FAIL async_count got=%0d exp=0", bus.write_count);
      else n_pass++;
      @(negedge clock);
      bus.ctrl_writeEnable = 1'b0;
      ctrl_reset = 1'b0;
      repeat (2) @(negedge clock);
      #1;
      n_checks++;
      if (bus.data_readRegB !== 32'h0) $display("[TB] FAIL async_lost_write got=%h exp=00000000", bus.data_readRegB);
      else n_pass++;
      n_checks++;
      if (bus.write_count !== 16'd0) $display("[TB] FAIL async_post_count got=%0d exp=0", bus.write_count);
      else n_pass++;
      write_reg(5'd9, 32'h0000BEEF);
      #1;
      n_checks++;
      if (bus.data_readRegB !== 32'h0000BEEF || bus.write_count !== 16'd1)
         $display("[TB] FAIL after_release got=%h/%0d exp=0000beef/1", bus.data_readRegB, bus.write_count);
      else n_pass++;
   endtask

   initial begin
      n_pass   = 0;
      n_checks = 0;
      ctrl_reset           = 1'b1;
      bus.ctrl_writeEnable = 1'b0;
      bus.ctrl_writeReg    = '0;
      bus.data_writeReg    = '0;
      bus.ctrl_readRegA    = '0;
      bus.ctrl_readRegB    = '0;

      test_reset();
      test_basic_write();
      test_reg0_write();
      test_fill_dual_read();
      test_same_cycle();
      test_async_reset();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
